// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative 16-bit multiply/divide unit feeding the register-file
// write ports. One operation is in flight at a time. Each operation takes 16
// iterations, one per cycle, and its result is presented for one DONE cycle.
//
// Build option: MD_SIGNED_EN. When defined, sgn selects two's-complement
// operation. When undefined, every operation is unsigned and no sign logic exists.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, op, sgn    request (sampled in IDLE), 0=mul/1=div, signed select
//   op_a, op_b        multiplicand/dividend, multiplier/divisor
//   dest_rn           destination register for the main result
//   busy, done        busy in CALC/DONE, one-cycle completion pulse
//   wrn, wrd, wr      main result write port (product low / quotient)
//   r0d, wr0          R0 write port (product high / remainder)
//   exception         one-cycle pulse on divide by zero
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one shift-add or restoring-divide step per cycle, cnt 0..15
// DONE  | results valid, write enables or exception pulsed for one cycle
module mul_div_unit #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int REG_NUM_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op,
    input  logic                      sgn,
    input  logic [REG_DATA_WIDTH-1:0] op_a,
    input  logic [REG_DATA_WIDTH-1:0] op_b,
    input  logic [REG_NUM_WIDTH-1:0]  dest_rn,
    output logic                      busy,
    output logic                      done,
    output logic [REG_NUM_WIDTH-1:0]  wrn,
    output logic [REG_DATA_WIDTH-1:0] wrd,
    output logic                      wr,
    output logic [REG_DATA_WIDTH-1:0] r0d,
    output logic                      wr0,
    output logic                      exception
);
    localparam int W = REG_DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               cnt;
    logic                     op_q;
    logic                     exc_q;
    logic [REG_NUM_WIDTH-1:0] dest_q;
    logic [W-1:0]             opnd_q;   // multiplicand or divisor magnitude
    logic [W-1:0]             hi_q;     // product high / partial remainder
    logic [W-1:0]             lo_q;     // multiplier/product low or dividend/quotient
    logic [W-1:0]             hi_nxt, lo_nxt;
    logic [W-1:0]             res_lo, res_hi;
    logic [W-1:0]             a_mag, b_mag;
    logic [W:0]               sum;
    logic [W:0]               rem_shift;
    logic                     borrow;
    logic                     div_zero;

    assign div_zero = op && (op_b == '0);

`ifdef MD_SIGNED_EN
    logic neg_res_q, neg_rem_q;

    assign a_mag = (sgn && op_a[W-1]) ? W'(-op_a) : op_a;
    assign b_mag = (sgn && op_b[W-1]) ? W'(-op_b) : op_b;

    always_comb begin
        res_lo = lo_nxt;
        res_hi = hi_nxt;
        if (!op_q) begin
            if (neg_res_q) {res_hi, res_lo} = 32'(-{hi_nxt, lo_nxt});
        end else begin
            if (neg_res_q) res_lo = W'(-lo_nxt);
            if (neg_rem_q) res_hi = W'(-hi_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_res_q <= sgn && (op_a[W-1] ^ op_b[W-1]);
            // remainder follows the dividend; a multiply never looks at this
            neg_rem_q <= sgn && op_a[W-1];
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign a_mag  = op_a;
    assign b_mag  = op_b;
    assign res_lo = lo_nxt;
    assign res_hi = hi_nxt;
`endif

    // One iteration of the selected algorithm.
    always_comb begin
        sum       = '0;
        rem_shift = '0;
        borrow    = 1'b0;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        if (!op_q) begin
            sum    = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
            hi_nxt = sum[W:1];
            lo_nxt = {sum[0], lo_q[W-1:1]};
        end else begin
            rem_shift = {hi_q, lo_q[W-1]};
            borrow    = rem_shift < {1'b0, opnd_q};
            // on success the difference is below the divisor, so 16-bit
            // modular subtraction gives it exactly
            hi_nxt    = borrow ? rem_shift[W-1:0] : (rem_shift[W-1:0] - opnd_q);
            lo_nxt    = {lo_q[W-2:0], ~borrow};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = div_zero ? S_DONE : S_CALC;
            S_CALC: if (cnt == 4'd15) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        wr        = done && !exc_q;
        wr0       = done && !exc_q;
        exception = done && exc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_q   <= 1'b0;
            exc_q  <= 1'b0;
            dest_q <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            wrn    <= '0;
            wrd    <= '0;
            r0d    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q   <= op;
                    dest_q <= dest_rn;
                    cnt    <= '0;
                    exc_q  <= div_zero;
                    hi_q   <= '0;
                    opnd_q <= op ? b_mag : a_mag;
                    lo_q   <= op ? a_mag : b_mag;
                    if (div_zero) begin
                        wrn <= dest_rn;
                        wrd <= '0;
                        r0d <= '0;
                    end
                end
                S_CALC: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        wrn <= dest_q;
                        wrd <= res_lo;
                        r0d <= res_hi;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
`ifdef MD_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, op, sgn;
    logic [15:0] op_a, op_b, wrd, r0d;
    logic [3:0]  dest_rn, wrn;
    logic        busy, done, wr, wr0, exception;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn),
        .op_a(op_a), .op_b(op_b), .dest_rn(dest_rn),
        .busy(busy), .done(done), .wrn(wrn), .wrd(wrd), .wr(wr),
        .r0d(r0d), .wr0(wr0), .exception(exception)
    );

    typedef struct {
        logic        op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dest;
        logic [15:0] e_wrd;
        logic [15:0] e_r0d;
        logic        e_exc;
        int          e_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue a request at a negedge and count cycles until done (bounded).
    task automatic run_op(input logic o, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] d, output int lat);
        start = 1'b1; op = o; sgn = s; op_a = a; op_b = b; dest_rn = d;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int n_done;
    int n_wr;
    logic saw_exc;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h0F00, 16'h0050, 4'd3, 16'hB000, 16'h0004, 1'b0, 17};
        vecs[1] = '{1'b1, 1'b0, 16'hFF0F, 16'h0040, 4'd5, 16'h03FC, 16'h000F, 1'b0, 17};
        vecs[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 4'd7, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[3] = '{1'b1, 1'b1, 16'hFFF9, 16'h0002, 4'd2,
                    SGN_EN ? 16'hFFFD : 16'h7FFC, SGN_EN ? 16'hFFFF : 16'h0001, 1'b0, 17};
        vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 4'd9, 16'h0001, 16'hFFFE, 1'b0, 17};
        vecs[5] = '{1'b1, 1'b1, 16'h8000, 16'hFFFF, 4'd4,
                    SGN_EN ? 16'h8000 : 16'h0000, SGN_EN ? 16'h0000 : 16'h8000, 1'b0, 17};
        vecs[6] = '{1'b0, 1'b1, 16'hFFFE, 16'h0003, 4'd0,
                    16'hFFFA, SGN_EN ? 16'hFFFF : 16'h0002, 1'b0, 17};
        vecs[7] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 4'd1, 16'h0000, 16'h0005, 1'b0, 17};
        vecs[8] = '{1'b1, 1'b1, 16'h0007, 16'hFFFE, 4'd6,
                    SGN_EN ? 16'hFFFD : 16'h0000, SGN_EN ? 16'h0001 : 16'h0007, 1'b0, 17};
        vecs[9] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 4'd8, 16'h0000, 16'h0000, 1'b0, 17};

        rst = 1'b0; start = 1'b0; op = 1'b0; sgn = 1'b0;
        op_a = '0; op_b = '0; dest_rn = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, wr, wr0, exception, wrn, wrd, r0d}, '0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].op, vecs[v].sgn, vecs[v].a, vecs[v].b, vecs[v].dest, lat);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].e_lat);
            chk($sformatf("v%0d_exception", v), exception, vecs[v].e_exc);
            chk($sformatf("v%0d_wr", v), wr, !vecs[v].e_exc);
            chk($sformatf("v%0d_wr0", v), wr0, !vecs[v].e_exc);
            chk($sformatf("v%0d_busy", v), busy, 1'b1);
            if (!vecs[v].e_exc) chk($sformatf("v%0d_wrn", v), wrn, vecs[v].dest);
            chk($sformatf("v%0d_wrd", v), wrd, vecs[v].e_wrd);
            chk($sformatf("v%0d_r0d", v), r0d, vecs[v].e_r0d);
            @(negedge clk);
            chk($sformatf("v%0d_after_pulse", v), {busy, done, wr, wr0, exception}, '0);
            chk($sformatf("v%0d_wrd_hold", v), wrd, vecs[v].e_wrd);
        end

        // A second start (a divide by zero) during a multiply must be ignored.
        start = 1'b1; op = 1'b0; sgn = 1'b0; op_a = 16'h0F00; op_b = 16'h0050; dest_rn = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0; saw_exc = 1'b0; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1; op = 1'b1; op_a = 16'h1234; op_b = 16'h0000; dest_rn = 4'd7;
            end
            if (i == 6) start = 1'b0;
            if (exception) saw_exc = 1'b1;
            if (done) begin
                n_done++;
                if (lat < 0) begin
                    lat = i;
                    chk("ignored_start_wrd", wrd, 16'hB000);
                    chk("ignored_start_r0d", r0d, 16'h0004);
                    chk("ignored_start_wrn", wrn, 4'd3);
                end
            end
        end
        chk("ignored_start_done_count", n_done, 1);
        chk("ignored_start_latency", lat, 17);
        chk("ignored_start_no_exc", saw_exc, 1'b0);

        // Reset during a divide aborts it without any write.
        start = 1'b1; op = 1'b1; sgn = 1'b0; op_a = 16'hFF0F; op_b = 16'h0040; dest_rn = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, wr, wr0, exception, wrn, wrd, r0d}, '0);
        @(negedge clk);
        rst = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr || wr0 || done) n_wr++;
        end
        chk("abort_no_write", n_wr, 0);
        run_op(1'b1, 1'b0, 16'hFF0F, 16'h0040, 4'd5, lat);
        chk("post_reset_latency", lat, 17);
        chk("post_reset_wrd", wrd, 16'h03FC);
        chk("post_reset_r0d", r0d, 16'h000F);
        chk("post_reset_wr", {wr, wr0}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 16-bit multiply/divide unit that sits in the writeback path directly upstream of the register file. It accepts one operation at a time and computes for a fixed number of cycles. On completion it drives the register-file write ports in a single cycle: the main result goes to the destination register, and the high product or remainder goes to R0. A divide by zero raises an exception and produces no writes.

## Interface
Parameters:
- REG_DATA_WIDTH, 16, operand/result width (fixed at 16 for this release)
- REG_NUM_WIDTH, 4, register-number width

Ports (clock is `clk`; reset is `rst`, asynchronous, active-low):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide
- sgn  in  1  1 = signed (two's complement) operation; honoured only with MD_SIGNED_EN
- op_a  in  16  multiplicand / dividend
- op_b  in  16  multiplier / divisor
- dest_rn  in  4  destination register number for the main result
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle completion pulse
- wrn  out  4  register-file write number
- wrd  out  16  product low word / quotient
- wr  out  1  write enable for wrn
- r0d  out  16  product high word / remainder
- wr0  out  1  write enable for R0
- exception  out  1  one-cycle pulse on divide by zero

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC when start=1 and op_b != 0 or op=0. On entry, latch op, sgn, dest_rn, operand magnitudes, and result sign flags. Load cnt=0.
- IDLE -> DONE when start=1, op=1 and op_b=0 (divide by zero). Set the exception flag and skip CALC.
- CALC: exactly one iteration per cycle; cnt increments 0..15; at cnt=15 -> DONE.
  - Multiply: shift-add over a 32-bit accumulator {hi, lo}; unsigned magnitudes.
  - Divide: restoring division; 17-bit partial remainder; one quotient bit per cycle, MSB first.
- DONE (one cycle): apply sign correction, then assert done; return to IDLE unconditionally.
  - Normal completion: wr=1, wr0=1, wrn=dest_rn.
  - Divide by zero: wr=0, wr0=0, exception=1, wrd=r0d=0.
- Signed rules:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0x0000, no exception (wraps).
- dest_rn=0 gives a simultaneous wr and wr0 to R0. The register file applies wr0 last, so R0 ends up holding r0d. This is required behaviour.
- start is ignored while busy=1; there is no queueing.
- Outputs wrd, r0d, and wrn are registered. They hold their DONE values until the next DONE. wr, wr0, done, and exception are high only in DONE.

## Timing
- Reset values: busy=0, done=0, wr=0, wr0=0, exception=0, wrn=0, wrd=0, r0d=0; state=IDLE; cnt=0.
- Latency, normal operation: start sampled at edge N; CALC covers edges N+1..N+16; DONE outputs are valid in the cycle following edge N+16. That gives 17 cycles from start to done.
- Latency, divide by zero: done and exception are high in the cycle after the start edge.
- Throughput: the next start is accepted in the cycle after DONE. The peak rate is 1 op per 18 cycles.
- Reset asserted mid-operation: all state clears immediately. No write pulse is ever produced for the aborted operation.

## Configuration
- MD_SIGNED_EN defined: sgn is honoured. Sign/magnitude conversion happens at CALC entry and correction at DONE.
- MD_SIGNED_EN undefined: sgn is ignored, all operations are unsigned, and no sign logic is synthesised.

## Test plan
- Multiply 0x0F00 * 0x0050 (unsigned) -> after 17 cycles: done=1, wrd=0xB000, r0d=0x0004, wr=wr0=1, wrn=dest_rn.
- Divide 0xFF0F / 0x0040 (unsigned) -> wrd=0x03FC, r0d=0x000F; exception=0.
- Divide 0x1234 / 0x0000 -> next cycle: exception=1, done=1, wr=wr0=0.
- With MD_SIGNED_EN: divide 0xFFF9 / 0x0002 (sgn=1) -> wrd=0xFFFD, r0d=0xFFFF. Without MD_SIGNED_EN, the same stimulus -> wrd=0x7FFC, r0d=0x0001.
- start pulsed again at cycle 5 of a multiply -> ignored; exactly one done, with the original result.
- rst low at cycle 8 of a divide, then released -> busy=0 and all outputs 0; no wr/wr0 pulse; a new start then completes normally.
